// File: rtl/connect_four_turn_ctrl.sv
// Connect Four game sequencer: owns the board, alternates human/AI turns,
// animates each drop one row per cycle and hands the placed cell to a win checker.
module connect_four_turn_ctrl #(
  parameter int ROWS       = 6,
  parameter int COLS       = 8,
  parameter int AI_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_game,
  input  logic                     ai_enable,
  input  logic                     btn_left,
  input  logic                     btn_right,
  input  logic                     btn_drop,
  output logic                     ai_start,
  input  logic                     ai_done,
  input  logic [2:0]               ai_col,
  output logic                     win_check,
  output logic [2:0]               win_row,
  output logic [2:0]               win_col,
  input  logic                     win_valid,
  input  logic                     win_found,
  output logic [2*ROWS*COLS-1:0]   board,
  output logic [2:0]               cursor,
  output logic [1:0]               cur_player,
  output logic                     game_over,
  output logic [1:0]               winner
);

  localparam int CELLS = ROWS * COLS;
  localparam int TW    = $clog2(AI_TIMEOUT + 1);

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;

  typedef enum logic [2:0] {
    IDLE, INPUT_HUMAN, INPUT_AI, DROP, CHECK, SWITCH, GAME_OVER
  } state_t;

  state_t                              state_q, state_d;
  logic [ROWS-1:0][COLS-1:0][1:0]      cells_q, cells_d;
  logic [2:0]                          cursor_q, cursor_d;
  logic [1:0]                          player_q, player_d;
  logic [5:0]                          move_cnt_q, move_cnt_d;
  logic                                ai_en_q, ai_en_d;
  logic [TW-1:0]                       timer_q, timer_d;
  logic [2:0]                          drop_col_q, drop_col_d;
  logic [2:0]                          drop_row_q, drop_row_d;
  logic [2:0]                          win_row_q, win_row_d;
  logic [2:0]                          win_col_q, win_col_d;
  logic                                win_check_q, win_check_d;
  logic                                game_over_q, game_over_d;
  logic [1:0]                          winner_q, winner_d;

  logic [2:0] fallback_col;
  logic       ai_col_ok;
  logic [2:0] ai_pick;

  // Descending scan so the lowest-index non-full column wins.
  always_comb begin
    fallback_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (cells_q[0][c] == EMPTY) fallback_col = 3'(c);
    end
  end

  assign ai_col_ok = (int'(ai_col) < COLS) && (cells_q[0][ai_col] == EMPTY);
  assign ai_pick   = ai_col_ok ? ai_col : fallback_col;

  // NOTE: every next-state value gets its default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cells_d     = cells_q;
    cursor_d    = cursor_q;
    player_d    = player_q;
    move_cnt_d  = move_cnt_q;
    ai_en_d     = ai_en_q;
    timer_d     = timer_q;
    drop_col_d  = drop_col_q;
    drop_row_d  = drop_row_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_check_d = 1'b0;
    game_over_d = game_over_q;
    winner_d    = winner_q;

    if (start_game) begin
      cells_d     = '0;
      move_cnt_d  = '0;
      cursor_d    = '0;
      player_d    = P1;
      game_over_d = 1'b0;
      winner_d    = EMPTY;
      ai_en_d     = ai_enable;
      state_d     = INPUT_HUMAN;
    end else begin
      case (state_q)
        INPUT_HUMAN: begin
          // An accepted drop uses the pre-move cursor and swallows any move.
          if (btn_drop && cells_q[0][cursor_q] == EMPTY) begin
            drop_col_d = cursor_q;
            drop_row_d = 3'(ROWS - 1);
            state_d    = DROP;
          end else if (btn_left && !btn_right) begin
            cursor_d = (cursor_q == 3'd0) ? 3'(COLS - 1) : cursor_q - 3'd1;
          end else if (btn_right && !btn_left) begin
            cursor_d = (cursor_q == 3'(COLS - 1)) ? 3'd0 : cursor_q + 3'd1;
          end
        end

        INPUT_AI: begin
          timer_d = timer_q + 1'b1;
          if (ai_done) begin
            drop_col_d = ai_pick;
            cursor_d   = ai_pick;
            drop_row_d = 3'(ROWS - 1);
            state_d    = DROP;
          end else if (timer_q == TW'(AI_TIMEOUT - 1)) begin
            drop_col_d = fallback_col;
            cursor_d   = fallback_col;
            drop_row_d = 3'(ROWS - 1);
            state_d    = DROP;
          end
        end

        DROP: begin
          if (cells_q[drop_row_q][drop_col_q] == EMPTY) begin
            cells_d[drop_row_q][drop_col_q] = player_q;
            win_row_d   = drop_row_q;
            win_col_d   = drop_col_q;
            win_check_d = 1'b1;
            if (move_cnt_q != 6'(CELLS)) move_cnt_d = move_cnt_q + 6'd1;
            state_d     = CHECK;
          end else begin
            drop_row_d = drop_row_q - 3'd1;
          end
        end

        CHECK: begin
          if (win_valid) begin
            if (win_found) begin
              winner_d    = player_q;
              game_over_d = 1'b1;
              state_d     = GAME_OVER;
            end else if (move_cnt_q == 6'(CELLS)) begin
              winner_d    = EMPTY;
              game_over_d = 1'b1;
              state_d     = GAME_OVER;
            end else begin
              state_d = SWITCH;
            end
          end
        end

        SWITCH: begin
          player_d = (player_q == P1) ? P2 : P1;
          if (player_q == P1 && ai_en_q) begin
            timer_d = '0;
            state_d = INPUT_AI;
          end else begin
            state_d = INPUT_HUMAN;
          end
        end

        IDLE, GAME_OVER: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the board is a register array, not a RAM, so it is cleared by reset like any other state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cells_q     <= '0;
      cursor_q    <= '0;
      player_q    <= P1;
      move_cnt_q  <= '0;
      ai_en_q     <= 1'b0;
      timer_q     <= '0;
      drop_col_q  <= '0;
      drop_row_q  <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_check_q <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= EMPTY;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values together.
      state_q     <= state_d;
      cells_q     <= cells_d;
      cursor_q    <= cursor_d;
      player_q    <= player_d;
      move_cnt_q  <= move_cnt_d;
      ai_en_q     <= ai_en_d;
      timer_q     <= timer_d;
      drop_col_q  <= drop_col_d;
      drop_row_q  <= drop_row_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_check_q <= win_check_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign ai_start   = (state_q == INPUT_AI);
  assign win_check  = win_check_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign board      = cells_q;
  assign cursor     = cursor_q;
  assign cur_player = player_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_connect_four_turn_ctrl.sv
// Directed bench for connect_four_turn_ctrl: a board model plus a scripted
// win checker and AI drive each scenario and compare against the model.
module tb_connect_four_turn_ctrl;

  localparam int ROWS       = 6;
  localparam int COLS       = 8;
  localparam int AI_TIMEOUT = 64;
  localparam int BW         = 2 * ROWS * COLS;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_game, ai_enable, btn_left, btn_right, btn_drop;
  logic          ai_start, ai_done;
  logic [2:0]    ai_col;
  logic          win_check, win_valid, win_found;
  logic [2:0]    win_row, win_col, cursor;
  logic [BW-1:0] board;
  logic [1:0]    cur_player, winner;
  logic          game_over;

  int            errors = 0;
  int            checks = 0;
  logic [BW-1:0] exp_board;
  logic [1:0]    exp_player;
  int            exp_moves;

  connect_four_turn_ctrl #(.ROWS(ROWS), .COLS(COLS), .AI_TIMEOUT(AI_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start_game(start_game), .ai_enable(ai_enable),
    .btn_left(btn_left), .btn_right(btn_right), .btn_drop(btn_drop),
    .ai_start(ai_start), .ai_done(ai_done), .ai_col(ai_col),
    .win_check(win_check), .win_row(win_row), .win_col(win_col),
    .win_valid(win_valid), .win_found(win_found), .board(board),
    .cursor(cursor), .cur_player(cur_player), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] model_cell(input int r, input int c);
    return exp_board[(r*COLS+c)*2 +: 2];
  endfunction

  function automatic int low_row(input int c);
    for (int r = ROWS - 1; r >= 0; r--) if (model_cell(r, c) == 2'b00) return r;
    return -1;
  endfunction

  task automatic new_game(input logic ai);
    ai_enable  = ai;
    start_game = 1'b1;
    tick();
    start_game = 1'b0;
    ai_enable  = 1'b0;
    exp_board  = '0;
    exp_player = 2'b01;
    exp_moves  = 0;
  endtask

  task automatic press(input int which);
    btn_left  = (which == 0);
    btn_right = (which == 1);
    btn_drop  = (which == 2);
    tick();
    btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0;
  endtask

  task automatic move_to(input int col);
    for (int i = 0; i < COLS && cursor !== 3'(col); i++) press(1);
  endtask

  // Called on the first DROP cycle; waits for the write, checks it, then answers the checker.
  task automatic finish_move(input int r, input int c, input logic found);
    int n;
    n = 0;
    while (win_check !== 1'b1 && n < 2*ROWS) begin tick(); n++; end
    checks++;
    if (win_check !== 1'b1 || n != ROWS - r) begin
      errors++;
      $display("FAIL drop_latency: win_check=%b after %0d cycles, expected 1 after %0d", win_check, n, ROWS - r);
    end
    exp_board[(r*COLS+c)*2 +: 2] = exp_player;
    exp_moves++;
    checks++;
    if (board !== exp_board) begin
      errors++;
      $display("FAIL board_after_drop: got %h expected %h", board, exp_board);
    end
    checks++;
    if (win_row !== 3'(r) || win_col !== 3'(c)) begin
      errors++;
      $display("FAIL win_pos: got row %0d col %0d expected row %0d col %0d", win_row, win_col, r, c);
    end
    win_valid = 1'b1; win_found = found;
    tick();
    win_valid = 1'b0; win_found = 1'b0;
    if (!found && exp_moves < ROWS*COLS) begin
      tick();
      exp_player = (exp_player == 2'b01) ? 2'b10 : 2'b01;
      checks++;
      if (cur_player !== exp_player) begin
        errors++;
        $display("FAIL player_switch: got %b expected %b", cur_player, exp_player);
      end
    end
  endtask

  task automatic human_move(input int col, input logic found);
    int r;
    move_to(col);
    r = low_row(col);
    press(2);
    finish_move(r, col, found);
  endtask

  task automatic ai_move(input int delay, input logic use_done, input logic [2:0] col,
                         input int exp_col, input int exp_cycles);
    int n;
    int r;
    n = 0;
    r = low_row(exp_col);
    while (ai_start === 1'b1 && n < 4*AI_TIMEOUT) begin
      n++;
      if (use_done && n == delay + 1) begin ai_done = 1'b1; ai_col = col; end
      tick();
    end
    ai_done = 1'b0;
    checks++;
    if (n != exp_cycles) begin
      errors++;
      $display("FAIL ai_start_len: high for %0d cycles, expected %0d", n, exp_cycles);
    end
    checks++;
    if (cursor !== 3'(exp_col)) begin
      errors++;
      $display("FAIL ai_cursor: got %0d expected %0d", cursor, exp_col);
    end
    finish_move(r, exp_col, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if (board !== '0 || cursor !== 3'd0 || cur_player !== 2'b01) begin
      errors++;
      $display("FAIL reset_state: board=%h cursor=%0d player=%b", board, cursor, cur_player);
    end
    checks++;
    if (ai_start !== 1'b0 || win_check !== 1'b0 || game_over !== 1'b0 || winner !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: ai_start=%b win_check=%b game_over=%b winner=%b", ai_start, win_check, game_over, winner);
    end
    checks++;
    if (win_row !== 3'd0 || win_col !== 3'd0) begin
      errors++;
      $display("FAIL reset_win_pos: row=%0d col=%0d expected 0/0", win_row, win_col);
    end
    reset = 1'b1;
    tick();
    press(1);
    checks++;
    if (cursor !== 3'd0) begin
      errors++;
      $display("FAIL idle_ignores_buttons: cursor=%0d expected 0", cursor);
    end
  endtask

  task automatic test_first_drop();
    new_game(1'b0);
    repeat (3) press(1);
    checks++;
    if (cursor !== 3'd3) begin errors++; $display("FAIL cursor_right: got %0d expected 3", cursor); end
    press(2);
    tick();
    checks++;
    if (win_check !== 1'b1 || board[(5*COLS+3)*2 +: 2] !== 2'b01 || win_row !== 3'd5 || win_col !== 3'd3) begin
      errors++;
      $display("FAIL first_drop: win_check=%b cell=%b row=%0d col=%0d expected 1/01/5/3",
               win_check, board[(5*COLS+3)*2 +: 2], win_row, win_col);
    end
    tick();
    checks++;
    if (win_check !== 1'b0) begin errors++; $display("FAIL win_check_pulse: got %b expected 0", win_check); end
    win_valid = 1'b1; win_found = 1'b0;
    tick();
    win_valid = 1'b0;
    tick();
    checks++;
    if (cur_player !== 2'b10) begin errors++; $display("FAIL first_switch: got %b expected 10", cur_player); end
    exp_board[(5*COLS+3)*2 +: 2] = 2'b01;
    exp_moves  = 1;
    exp_player = 2'b10;
  endtask

  task automatic test_full_column();
    bit saw_check;
    for (int k = 0; k < ROWS; k++) human_move(2, 1'b0);
    move_to(2);
    press(2);
    saw_check = 1'b0;
    for (int k = 0; k < 2*ROWS; k++) begin
      if (win_check === 1'b1) saw_check = 1'b1;
      tick();
    end
    checks++;
    if (board !== exp_board || saw_check) begin
      errors++;
      $display("FAIL full_column_drop: board=%h expected %h win_check_seen=%b", board, exp_board, saw_check);
    end
    press(0); press(0);
    checks++;
    if (cursor !== 3'd0) begin errors++; $display("FAIL cursor_left: got %0d expected 0", cursor); end
    press(0);
    checks++;
    if (cursor !== 3'd7) begin errors++; $display("FAIL cursor_wrap_left: got %0d expected 7", cursor); end
    btn_left = 1'b1; btn_right = 1'b1;
    tick();
    btn_left = 1'b0; btn_right = 1'b0;
    checks++;
    if (cursor !== 3'd7) begin errors++; $display("FAIL left_right_same_cycle: got %0d expected 7", cursor); end
    press(1);
    checks++;
    if (cursor !== 3'd0) begin errors++; $display("FAIL cursor_wrap_right: got %0d expected 0", cursor); end
  endtask

  task automatic test_ai();
    new_game(1'b1);
    human_move(0, 1'b0);
    checks++;
    if (ai_start !== 1'b1) begin errors++; $display("FAIL ai_start_entry: got %b expected 1", ai_start); end
    ai_move(4, 1'b1, 3'd5, 5, 5);
    for (int k = 0; k < 3; k++) begin
      human_move(7, 1'b0);
      ai_move(0, 1'b1, 3'd7, 7, 1);
    end
    human_move(1, 1'b0);
    ai_move(1, 1'b1, 3'd7, 0, 2);
    human_move(1, 1'b0);
    ai_move(0, 1'b0, 3'd0, 0, AI_TIMEOUT);
  endtask

  task automatic test_win();
    new_game(1'b0);
    for (int k = 0; k < 6; k++) human_move(k % 2, 1'b0);
    human_move(0, 1'b1);
    checks++;
    if (game_over !== 1'b1 || winner !== 2'b01) begin
      errors++;
      $display("FAIL win_declared: game_over=%b winner=%b expected 1/01", game_over, winner);
    end
    press(1); press(2); press(0);
    repeat (ROWS + 2) tick();
    checks++;
    if (board !== exp_board || cursor !== 3'd0 || game_over !== 1'b1) begin
      errors++;
      $display("FAIL game_over_frozen: board=%h cursor=%0d game_over=%b", board, cursor, game_over);
    end
  endtask

  task automatic test_draw();
    new_game(1'b0);
    for (int c = 0; c < COLS; c++)
      for (int k = 0; k < ROWS; k++) human_move(c, 1'b0);
    checks++;
    if (game_over !== 1'b1 || winner !== 2'b00) begin
      errors++;
      $display("FAIL draw: game_over=%b winner=%b expected 1/00", game_over, winner);
    end
  endtask

  task automatic test_reset_mid_drop();
    new_game(1'b0);
    human_move(3, 1'b0);
    human_move(3, 1'b0);
    press(2);
    tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (board !== '0 || cursor !== 3'd0 || cur_player !== 2'b01 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_state: board=%h cursor=%0d player=%b game_over=%b", board, cursor, cur_player, game_over);
    end
    checks++;
    if (win_row !== 3'd0 || win_col !== 3'd0 || win_check !== 1'b0 || ai_start !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_flags: row=%0d col=%0d win_check=%b ai_start=%b", win_row, win_col, win_check, ai_start);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_start_mid_check();
    int n;
    new_game(1'b0);
    human_move(4, 1'b0);
    press(2);
    n = 0;
    while (win_check !== 1'b1 && n < 2*ROWS) begin tick(); n++; end
    checks++;
    if (win_check !== 1'b1) begin errors++; $display("FAIL reach_check: win_check=%b expected 1", win_check); end
    new_game(1'b0);
    checks++;
    if (board !== '0 || cursor !== 3'd0 || cur_player !== 2'b01 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL restart_mid_check: board=%h cursor=%0d player=%b game_over=%b", board, cursor, cur_player, game_over);
    end
    win_valid = 1'b1; win_found = 1'b1;
    tick();
    win_valid = 1'b0; win_found = 1'b0;
    checks++;
    if (game_over !== 1'b0 || winner !== 2'b00) begin
      errors++;
      $display("FAIL stale_win_valid: game_over=%b winner=%b expected 0/00", game_over, winner);
    end
    human_move(6, 1'b0);
  endtask

  initial begin
    start_game = 1'b0; ai_enable = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0;
    ai_done = 1'b0; ai_col = 3'd0;
    win_valid = 1'b0; win_found = 1'b0;
    exp_board = '0; exp_player = 2'b01; exp_moves = 0;
    test_reset();
    test_first_drop();
    test_full_column();
    test_ai();
    test_win();
    test_draw();
    test_reset_mid_drop();
    test_start_mid_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/connect_four_turn_ctrl.md
Name: connect_four_turn_ctrl

Overview:
- Game-level sequencer for Connect Four: owns the board register array, runs human/AI turns, and animates each piece drop row by row.
- Hands the last-placed cell to an external win checker and declares a win or draw.
- Sits between debounced button inputs, the AI block (ai_start/ai_done handshake) and the VGA/board renderer.

Parameters:
ROWS, 6, board rows; row 0 is the top row.
COLS, 8, board columns; column index is 3 bits wide.
AI_TIMEOUT, 64, cycles to wait for ai_done before the fallback move.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start_game  in  1  one-cycle pulse; clears the board and starts a new game
ai_enable  in  1  1 = player 2 is the AI; sampled on start_game only
btn_left  in  1  one-cycle pulse; move cursor left
btn_right  in  1  one-cycle pulse; move cursor right
btn_drop  in  1  one-cycle pulse; drop a piece at the cursor
ai_start  out  1  high throughout the AI turn-input state
ai_done  in  1  AI result valid; held high by the AI until ai_start falls
ai_col  in  3  AI-chosen column
win_check  out  1  one-cycle request to the win checker
win_row  out  3  row of the last placed piece
win_col  out  3  column of the last placed piece
win_valid  in  1  checker response strobe
win_found  in  1  checker result; qualified by win_valid
board  out  2 x ROWS x COLS  cell encoding: 00 empty, 01 player 1, 10 player 2
cursor  out  3  current column
cur_player  out  2  01 or 10
game_over  out  1  game ended
winner  out  2  00 draw or none, 01 player 1, 10 player 2

Behaviour:
- Reset (reset low, asynchronous):
  - all cells 00; cursor 0; cur_player 01; move count 0.
  - ai_start, win_check, game_over all 0; winner 00; win_row/win_col 0.
  - state IDLE.
- FSM states: IDLE, INPUT_HUMAN, INPUT_AI, DROP, CHECK, SWITCH, GAME_OVER.
- IDLE: waits for start_game.
- start_game (any state, highest priority, including mid-DROP or mid-CHECK):
  - next cycle: board cleared, move count 0, cursor 0, cur_player 01, game_over 0, winner 00.
  - ai_enable latched; state goes to INPUT_HUMAN.
  - any outstanding win_valid is ignored.
- INPUT_HUMAN:
  - btn_left / btn_right move the cursor with wrap-around (0 -> COLS-1 on left, COLS-1 -> 0 on right).
  - left and right in the same cycle: no move.
  - btn_drop: if board[0][cursor] is empty, latch the column and go to DROP; otherwise ignore it and stay.
  - btn_drop together with a move in the same cycle: the drop uses the pre-move cursor and the move is discarded.
  - Buttons are ignored in every other state.
- INPUT_AI (entered only when cur_player = 10 and ai_enable is latched):
  - ai_start = 1 for the whole state; the timeout counter is cleared on entry.
  - On the first cycle ai_done = 1: sample ai_col and go to DROP. ai_start falls the next cycle.
  - If ai_col >= COLS or that column is full, substitute the lowest-index non-full column.
  - If AI_TIMEOUT cycles elapse without ai_done: use the same lowest-index fallback and go to DROP.
  - The cursor follows the chosen column.
- DROP:
  - Scans one row per cycle, starting at row ROWS-1 and moving upward.
  - On the first empty row r: write cur_player into cell [r][col], latch win_row = r and win_col = col, increment move count, go to CHECK.
  - Latency from DROP entry to the write is (ROWS-1-r)+1 cycles, so an empty column takes 1 cycle and a column needing row 0 takes ROWS cycles.
  - The column is guaranteed non-full on entry.
- CHECK:
  - win_check is pulsed on the entry cycle only, then the block waits for win_valid. There is no timeout.
  - win_valid with win_found = 1: winner = cur_player, game_over = 1, go to GAME_OVER.
  - Otherwise, if move count = ROWS*COLS: winner = 00, game_over = 1, go to GAME_OVER.
  - Otherwise go to SWITCH.
- SWITCH (1 cycle): toggle cur_player, then go to INPUT_AI if the new player is 10 and AI is enabled, else INPUT_HUMAN.
  - This guarantees ai_start is low for at least 2 cycles between AI turns.
- GAME_OVER: board frozen, outputs held; only start_game or reset exits.
- Move counter: 6 bits, saturating, never exceeds ROWS*COLS.

Test Plan:
- Reset, start_game, 3x btn_right, btn_drop -> board[5][3] = 01, win_check pulses with row 5 / col 3; reply win_valid=1, win_found=0 -> cur_player = 10.
- Column 2 filled to 6 pieces, then btn_drop on column 2 -> no write, state stays INPUT_HUMAN; btn_left at cursor 0 -> cursor 7; left+right in the same cycle -> cursor unchanged.
- ai_enable=1, player 2 turn; AI returns ai_done with ai_col=5 after 4 cycles -> ai_start high 5 cycles then low, piece 10 at the lowest empty row of column 5. Repeat with ai_col=7 full -> piece lands in column 0.
- ai_enable=1, ai_done never asserted -> after 64 cycles the piece lands in the lowest non-full column.
- Reply win_found=1 on the 7th move -> game_over=1, winner=01; further buttons do not change the board.
- 48 alternating non-winning moves -> winner=00, game_over=1. Assert reset low mid-DROP -> all outputs at reset values immediately; start_game mid-CHECK -> board cleared next cycle.
